// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the data-memory port between core MEM stage and debug port.
// Optional perf counters built only when DMEM_ARB_PERF_EN is defined.
module dmem_arbiter #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_rd,
    input  logic              core_wr,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    input  logic [2:0]        core_funct3,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_done,
    output logic              core_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_done,
    output logic              mem_en,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_funct3,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_conflict_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic OWN_CORE = 1'b0;
    localparam logic OWN_DBG  = 1'b1;

    state_t            r_state;
    logic              r_owner;
    logic              r_last;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_rd;
    logic              r_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [2:0]        r_funct3;

    logic w_core_req;
    logic w_pick_dbg;
    logic w_resp;
    logic w_conflict;

    assign w_core_req = core_rd | core_wr;
    // On a tie the requester that did not win last time takes the port.
    assign w_pick_dbg = dbg_req & (~w_core_req | (r_last == OWN_CORE));
    assign w_resp     = (r_state == S_RESP);
    assign w_conflict = (r_state == S_IDLE) & w_core_req & dbg_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_owner  <= OWN_CORE;
            r_last   <= OWN_DBG;
            r_cnt    <= '0;
            r_rd     <= 1'b0;
            r_wr     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_funct3 <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_core_req | dbg_req) begin
                        if (w_pick_dbg) begin
                            r_rd     <= ~dbg_we;
                            r_wr     <= dbg_we;
                            r_addr   <= dbg_addr;
                            r_wdata  <= dbg_wdata;
                            r_funct3 <= 3'b010;
                            r_owner  <= OWN_DBG;
                            r_last   <= OWN_DBG;
                        end else begin
                            r_rd     <= core_rd;
                            r_wr     <= core_wr;
                            r_addr   <= core_addr;
                            r_wdata  <= core_wdata;
                            r_funct3 <= core_funct3;
                            r_owner  <= OWN_CORE;
                            r_last   <= OWN_CORE;
                        end
                        r_cnt   <= CNT_W'(MEM_LAT - 1);
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_state <= (r_cnt != '0) ? S_WAIT : S_RESP;
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_en     = (r_state == S_ISSUE);
    assign mem_rd     = mem_en & r_rd;
    assign mem_wr     = mem_en & r_wr;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;
    assign mem_funct3 = r_funct3;

    assign core_done  = w_resp & (r_owner == OWN_CORE);
    assign dbg_done   = w_resp & (r_owner == OWN_DBG);
    assign core_rdata = core_done ? mem_rdata : '0;
    assign dbg_rdata  = dbg_done ? mem_rdata : '0;
    assign core_stall = w_core_req & ~core_done;

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_conflict;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_stall    <= '0;
            r_perf_conflict <= '0;
        end else begin
            if (core_stall) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            if (w_conflict) begin
                r_perf_conflict <= r_perf_conflict + 32'd1;
            end
        end
    end

    assign perf_stall_cnt    = r_perf_stall;
    assign perf_conflict_cnt = r_perf_conflict;
`else
    logic w_unused;
    assign w_unused          = w_conflict;
    assign perf_stall_cnt    = '0;
    assign perf_conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: MEM_LAT=1 instance with memory model, MEM_LAT=3 instance with fixed read data.
// Checks perf counters when DMEM_ARB_PERF_EN is defined, zero outputs otherwise.
module tb_dmem_arbiter;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests;
    int fails;

    // MEM_LAT=1 instance
    logic        rst;
    logic        c_rd, c_wr;
    logic [8:0]  c_addr;
    logic [31:0] c_wdata;
    logic [2:0]  c_f3;
    logic [31:0] c_rdata;
    logic        c_done, c_stall;
    logic        d_req, d_we;
    logic [8:0]  d_addr;
    logic [31:0] d_wdata, d_rdata;
    logic        d_done;
    logic        m_en, m_rd, m_wr;
    logic [8:0]  m_addr;
    logic [31:0] m_wdata, m_rdata;
    logic [2:0]  m_f3;
    logic [31:0] p_stall, p_conf;

    dmem_arbiter #(.MEM_LAT(1)) u1 (
        .clk(clk), .reset(rst),
        .core_rd(c_rd), .core_wr(c_wr), .core_addr(c_addr),
        .core_wdata(c_wdata), .core_funct3(c_f3),
        .core_rdata(c_rdata), .core_done(c_done), .core_stall(c_stall),
        .dbg_req(d_req), .dbg_we(d_we), .dbg_addr(d_addr),
        .dbg_wdata(d_wdata), .dbg_rdata(d_rdata), .dbg_done(d_done),
        .mem_en(m_en), .mem_rd(m_rd), .mem_wr(m_wr), .mem_addr(m_addr),
        .mem_wdata(m_wdata), .mem_funct3(m_f3), .mem_rdata(m_rdata),
        .perf_stall_cnt(p_stall), .perf_conflict_cnt(p_conf)
    );

    logic [31:0] mem [0:511];
    always @(posedge clk) begin
        if (rst) begin
            mem[9'h010] <= 32'hDEAD_BEEF;
            mem[9'h030] <= 32'hC0C0_0030;
            mem[9'h040] <= 32'hD0D0_0040;
            m_rdata     <= 32'h0;
        end else if (m_en) begin
            if (m_wr) mem[m_addr] <= m_wdata;
            if (m_rd) m_rdata <= mem[m_addr];
        end
    end

    // MEM_LAT=3 instance
    logic        r3;
    logic        c3_rd, c3_wr;
    logic [8:0]  c3_addr;
    logic [31:0] c3_wdata;
    logic [2:0]  c3_f3;
    logic [31:0] c3_rdata;
    logic        c3_done, c3_stall;
    logic        d3_req, d3_we;
    logic [8:0]  d3_addr;
    logic [31:0] d3_wdata, d3_rdata;
    logic        d3_done;
    logic        m3_en, m3_rd, m3_wr;
    logic [8:0]  m3_addr;
    logic [31:0] m3_wdata;
    logic [2:0]  m3_f3;
    logic [31:0] p3_stall, p3_conf;
    logic [31:0] m3_rdata;
    assign m3_rdata = 32'hA5A5_0003;

    dmem_arbiter #(.MEM_LAT(3)) u3 (
        .clk(clk), .reset(r3),
        .core_rd(c3_rd), .core_wr(c3_wr), .core_addr(c3_addr),
        .core_wdata(c3_wdata), .core_funct3(c3_f3),
        .core_rdata(c3_rdata), .core_done(c3_done), .core_stall(c3_stall),
        .dbg_req(d3_req), .dbg_we(d3_we), .dbg_addr(d3_addr),
        .dbg_wdata(d3_wdata), .dbg_rdata(d3_rdata), .dbg_done(d3_done),
        .mem_en(m3_en), .mem_rd(m3_rd), .mem_wr(m3_wr), .mem_addr(m3_addr),
        .mem_wdata(m3_wdata), .mem_funct3(m3_f3), .mem_rdata(m3_rdata),
        .perf_stall_cnt(p3_stall), .perf_conflict_cnt(p3_conf)
    );

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        crd, cwr;
        logic [8:0]  caddr;
        logic [2:0]  cf3;
        logic        dreq, dwe;
        logic [8:0]  daddr;
        logic [31:0] dwd;
        logic        men, mrd, mwr;
        logic [8:0]  maddr;
        logic [2:0]  mf3;
        logic        cdn, cst, ddn;
        logic [31:0] crdat, drdat;
    } vec_t;

    vec_t v [22];

    initial begin
        tests = 0;
        fails = 0;
        v[0]  = '{1,0,9'h010,3'd2, 0,0,9'h000,32'h0, 0,0,0,9'h000,3'd0, 0,1,0, 32'h0,32'h0};
        v[1]  = '{1,0,9'h010,3'd2, 0,0,9'h000,32'h0, 1,1,0,9'h010,3'd2, 0,1,0, 32'h0,32'h0};
        v[2]  = '{1,0,9'h010,3'd2, 0,0,9'h000,32'h0, 0,0,0,9'h010,3'd2, 1,0,0, 32'hDEADBEEF,32'h0};
        v[3]  = '{0,0,9'h000,3'd0, 0,0,9'h000,32'h0, 0,0,0,9'h010,3'd2, 0,0,0, 32'h0,32'h0};
        v[4]  = '{0,0,9'h000,3'd0, 1,1,9'h020,32'h12345678, 0,0,0,9'h010,3'd2, 0,0,0, 32'h0,32'h0};
        v[5]  = '{0,0,9'h000,3'd0, 1,1,9'h020,32'h12345678, 1,0,1,9'h020,3'd2, 0,0,0, 32'h0,32'h0};
        v[6]  = '{0,0,9'h000,3'd0, 1,1,9'h020,32'h12345678, 0,0,0,9'h020,3'd2, 0,0,1, 32'h0,32'hDEADBEEF};
        v[7]  = '{0,0,9'h000,3'd0, 0,0,9'h000,32'h0, 0,0,0,9'h020,3'd2, 0,0,0, 32'h0,32'h0};
        v[8]  = '{0,0,9'h000,3'd0, 1,0,9'h020,32'h0, 0,0,0,9'h020,3'd2, 0,0,0, 32'h0,32'h0};
        v[9]  = '{0,0,9'h000,3'd0, 1,0,9'h020,32'h0, 1,1,0,9'h020,3'd2, 0,0,0, 32'h0,32'h0};
        v[10] = '{0,0,9'h000,3'd0, 1,0,9'h020,32'h0, 0,0,0,9'h020,3'd2, 0,0,1, 32'h0,32'h12345678};
        v[11] = '{0,0,9'h000,3'd0, 0,0,9'h000,32'h0, 0,0,0,9'h020,3'd2, 0,0,0, 32'h0,32'h0};
        v[12] = '{1,0,9'h030,3'd1, 1,0,9'h040,32'h0, 0,0,0,9'h020,3'd2, 0,1,0, 32'h0,32'h0};
        v[13] = '{1,0,9'h030,3'd1, 1,0,9'h040,32'h0, 1,1,0,9'h030,3'd1, 0,1,0, 32'h0,32'h0};
        v[14] = '{1,0,9'h030,3'd1, 1,0,9'h040,32'h0, 0,0,0,9'h030,3'd1, 1,0,0, 32'hC0C00030,32'h0};
        v[15] = '{1,0,9'h030,3'd1, 1,0,9'h040,32'h0, 0,0,0,9'h030,3'd1, 0,1,0, 32'h0,32'h0};
        v[16] = '{1,0,9'h030,3'd1, 1,0,9'h040,32'h0, 1,1,0,9'h040,3'd2, 0,1,0, 32'h0,32'h0};
        v[17] = '{1,0,9'h030,3'd1, 1,0,9'h040,32'h0, 0,0,0,9'h040,3'd2, 0,1,1, 32'h0,32'hD0D00040};
        v[18] = '{1,0,9'h030,3'd1, 0,0,9'h000,32'h0, 0,0,0,9'h040,3'd2, 0,1,0, 32'h0,32'h0};
        v[19] = '{1,0,9'h030,3'd1, 0,0,9'h000,32'h0, 1,1,0,9'h030,3'd1, 0,1,0, 32'h0,32'h0};
        v[20] = '{1,0,9'h030,3'd1, 0,0,9'h000,32'h0, 0,0,0,9'h030,3'd1, 1,0,0, 32'hC0C00030,32'h0};
        v[21] = '{0,0,9'h000,3'd0, 0,0,9'h000,32'h0, 0,0,0,9'h030,3'd1, 0,0,0, 32'h0,32'h0};

        rst = 1'b1; r3 = 1'b1;
        c_rd = 0; c_wr = 0; c_addr = '0; c_wdata = '0; c_f3 = '0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        c3_rd = 0; c3_wr = 0; c3_addr = '0; c3_wdata = '0; c3_f3 = '0;
        d3_req = 0; d3_we = 0; d3_addr = '0; d3_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_u1", {c_rdata, c_done, c_stall, d_rdata, d_done, m_en, m_rd, m_wr,
                         m_addr, m_wdata, m_f3}, '0);
        chk("reset_u3", {c3_rdata, c3_done, c3_stall, d3_rdata, d3_done, m3_en, m3_rd,
                         m3_wr, m3_addr, m3_wdata, m3_f3}, '0);
        @(posedge clk); #1;
        rst = 1'b0; r3 = 1'b0;

        for (int i = 0; i < 22; i++) begin
            c_rd = v[i].crd; c_wr = v[i].cwr; c_addr = v[i].caddr; c_f3 = v[i].cf3;
            d_req = v[i].dreq; d_we = v[i].dwe; d_addr = v[i].daddr; d_wdata = v[i].dwd;
            @(negedge clk);
            chk($sformatf("vec%0d", i),
                {m_en, m_rd, m_wr, m_addr, m_f3, c_done, c_stall, d_done, c_rdata, d_rdata},
                {v[i].men, v[i].mrd, v[i].mwr, v[i].maddr, v[i].mf3,
                 v[i].cdn, v[i].cst, v[i].ddn, v[i].crdat, v[i].drdat});
            @(posedge clk); #1;
        end

`ifdef DMEM_ARB_PERF_EN
        chk("perf_u1", {p_stall, p_conf}, {32'd9, 32'd2});
`else
        chk("perf_u1", {p_stall, p_conf}, 64'h0);
`endif
        chk("perf_u3_idle_conf", p3_conf, 32'd0);

        // Core drops its read after one cycle; the access still completes.
        c_rd = 1; c_addr = 9'h010; c_f3 = 3'd2;
        @(negedge clk); chk("drop_t0", {m_en, c_stall}, 2'b01);
        @(posedge clk); #1; c_rd = 0;
        @(negedge clk); chk("drop_t1", {m_en, c_stall, c_done}, 3'b100);
        @(posedge clk); #1;
        @(negedge clk); chk("drop_t2", {c_done, c_rdata}, {1'b1, 32'hDEADBEEF});
        @(posedge clk); #1;
        @(negedge clk); chk("drop_t3", {c_done, m_en}, 2'b00);
        @(posedge clk); #1;

        // MEM_LAT=3 core write.
        begin
            logic [4:0] en_exp;
            logic [4:0] dn_exp;
            en_exp = 5'b00010;
            dn_exp = 5'b10000;
            c3_wr = 1; c3_addr = 9'h055; c3_wdata = 32'hCAFE_0055; c3_f3 = 3'd2;
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                chk($sformatf("lat3_wr%0d", k),
                    {m3_en, m3_wr, m3_rd, c3_done, c3_stall, m3_addr, m3_wdata, c3_rdata},
                    {en_exp[k], en_exp[k], 1'b0, dn_exp[k], ~dn_exp[k],
                     (k == 0) ? 9'h000 : 9'h055,
                     (k == 0) ? 32'h0 : 32'hCAFE_0055,
                     dn_exp[k] ? 32'hA5A5_0003 : 32'h0});
                @(posedge clk); #1;
            end
            c3_wr = 0;
            @(negedge clk);
            chk("lat3_wr_after", {c3_done, c3_stall, m3_en}, 3'b000);
            @(posedge clk); #1;
        end

        // MEM_LAT=3 read with reset asserted while in WAIT.
        begin
            logic [7:0] en_exp;
            logic [7:0] dn_exp;
            logic [8:0] a_exp;
            en_exp = 8'b0001_0010;
            dn_exp = 8'b1000_0000;
            c3_rd = 1; c3_addr = 9'h066; c3_f3 = 3'd2;
            for (int k = 0; k < 8; k++) begin
                r3 = (k == 2);
                a_exp = (k == 0) ? 9'h055 : (k == 3) ? 9'h000 : 9'h066;
                @(negedge clk);
                chk($sformatf("lat3_rst%0d", k),
                    {m3_en, c3_done, c3_stall, m3_addr},
                    {en_exp[k], dn_exp[k], ~dn_exp[k], a_exp});
                @(posedge clk); #1;
            end
            r3 = 0;
            c3_rd = 0;
            @(negedge clk);
            chk("lat3_rst_after", {c3_done, c3_stall, m3_en}, 3'b000);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
